imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Owns the single-port instruction memory and shares it between the Fetch stage and the program loader.
//  After reset (BOOT) the loader has exclusive access while Fetch is held; after boot_done (RUN) Fetch has priority.
//  In RUN the loader gets idle slots, plus a forced slot after MAX_WAIT cycles of starvation.
//  Sits between Fetch, the loader/debug port and the instruction RAM (synchronous read, 1-cycle latency).
// PARAMETERS
//  AW        7    word-address width (128 x 32-bit words)
//  MAX_WAIT  8    RUN-state loader starvation limit in cycles; 0 = never force a slot
// PORTS
//  clock        in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-low reset
//  boot_done    in   1   loader finished image load; one-cycle pulse or level
//  fetch_req    in   1   Fetch wants a read this cycle
//  fetch_addr   in   AW  Fetch word address (pc[AW+1:2])
//  fetch_gnt    out  1   Fetch read issued this cycle
//  fetch_rvalid out  1   fetch_rdata valid (read granted previous cycle)
//  fetch_rdata  out  32  instruction word
//  fetch_hold   out  1   Fetch must stall (held in BOOT or while a loader slot is forced)
//  ld_req       in   1   loader access request; held until ld_gnt
//  ld_we        in   1   1 = write, 0 = read
//  ld_addr      in   AW  loader word address
//  ld_wdata     in   32  loader write data
//  ld_gnt       out  1   loader access issued this cycle
//  ld_rvalid    out  1   ld_rdata valid (loader read granted previous cycle)
//  ld_rdata     out  32  loader read data
//  mem_en       out  1   RAM enable
//  mem_we       out  1   RAM write enable
//  mem_addr     out  AW  RAM address
//  mem_wdata    out  32  RAM write data
//  mem_rdata    in   32  RAM read data, valid one cycle after mem_en & !mem_we
//  arb_state    out  1   0 = BOOT, 1 = RUN
// BEHAVIOUR
//  Reset (async, active-low):
//   - state = BOOT, wait_cnt = 0, force = 0, pending read tag cleared
//   - all gnt/rvalid outputs 0; fetch_hold = 1
//   - a read in flight when reset asserts is dropped; no rvalid is produced for it
//  Grant logic is combinational in the current cycle. At most one grant per cycle.
//  mem_* outputs mirror the granted requester. With no grant: mem_en = 0, mem_we = 0, mem_addr/mem_wdata = 0.
//  BOOT state:
//   - ld_gnt = ld_req; fetch_gnt = 0; fetch_hold = 1
//   - boot_done moves to RUN on the next edge; an ld_req in the same cycle is still granted
//  RUN state (RUN is terminal until reset):
//   - force = (MAX_WAIT != 0) && (wait_cnt == MAX_WAIT)
//   - ld_gnt = ld_req & (!fetch_req | force)
//   - fetch_gnt = fetch_req & !ld_gnt
//   - fetch_hold = force
//   - wait_cnt: cleared on ld_gnt or !ld_req; otherwise incremented when ld_req & !ld_gnt; saturates at MAX_WAIT
//   - boot_done is ignored in RUN
//  Read return:
//   - a registered 1-bit owner tag plus valid records each granted read (loader writes record nothing)
//   - next cycle, the matching rvalid = 1 and its rdata = mem_rdata
//   - the non-owner rdata = 0
//   - rvalid is a one-cycle pulse; there is no back-pressure on returns
//  Loader writes and reads are allowed in RUN. A write followed by a Fetch read of the same address on the
//   next cycle returns the new data, since the RAM writes at the edge.
//  Simultaneous fetch_req & ld_req in RUN without force: Fetch wins and the loader waits.
// TESTING
//  1 Reset; ld_req/we=1 to addr 0..3, data A0..A3, fetch_req=1 -> ld_gnt each cycle, fetch_gnt=0, fetch_hold=1
//  2 boot_done pulse, then fetch_req addr 2 -> fetch_gnt same cycle; next cycle fetch_rvalid=1, fetch_rdata=A2
//  3 RUN, fetch_req held, ld_req read addr 1, MAX_WAIT=8 -> ld_gnt in cycle 9 with fetch_hold=1;
//    ld_rvalid=1, ld_rdata=A1 next cycle; wait_cnt back to 0
//  4 RUN, fetch_req=0, ld_req write addr 5 = 0xDEADBEEF, then fetch read addr 5 -> fetch_rdata=0xDEADBEEF
//  5 Fetch read granted, reset pulsed low before the next edge -> fetch_rvalid stays 0,
//    state=BOOT, fetch_hold=1
//  6 MAX_WAIT=0, fetch_req continuous, ld_req held 50 cycles -> ld_gnt never asserts, fetch_hold stays 0

Source files
------------

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: loader owns the RAM during BOOT, Fetch has priority in RUN,
// with a forced loader slot after MAX_WAIT starved cycles. Read data returns one cycle after grant.
module imem_arbiter #(
   parameter int unsigned AW       = 7,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          boot_done_i,
   input  logic          fetch_req_i,
   input  logic [AW-1:0] fetch_addr_i,
   output logic          fetch_gnt_o,
   output logic          fetch_rvalid_o,
   output logic [31:0]   fetch_rdata_o,
   output logic          fetch_hold_o,
   input  logic          ld_req_i,
   input  logic          ld_we_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [31:0]   ld_wdata_i,
   output logic          ld_gnt_o,
   output logic          ld_rvalid_o,
   output logic [31:0]   ld_rdata_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i,
   output logic          arb_state_o
);

   localparam int unsigned WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           rd_valid_q, rd_valid_d;
   logic           rd_ld_q, rd_ld_d;
   logic           force_slot;
   logic           ld_gnt;
   logic           fetch_gnt;
   logic           fetch_hold;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_BOOT;
         wait_cnt_q <= '0;
         rd_valid_q <= 1'b0;
         rd_ld_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_ld_q    <= rd_ld_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      force_slot = 1'b0;
      ld_gnt     = 1'b0;
      fetch_gnt  = 1'b0;
      fetch_hold = 1'b1;
      case (state_q)
         ST_BOOT: begin
            ld_gnt     = ld_req_i;
            wait_cnt_d = '0;
            if (boot_done_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            // MAX_WAIT == 0 disables forcing; the counter then stays pinned at zero
            force_slot = (MAX_WAIT != 0) && (wait_cnt_q == WAIT_LIMIT);
            ld_gnt     = ld_req_i & (!fetch_req_i | force_slot);
            fetch_gnt  = fetch_req_i & !ld_gnt;
            fetch_hold = force_slot;
            if (ld_gnt || !ld_req_i) begin
               wait_cnt_d = '0;
            end else if (wait_cnt_q != WAIT_LIMIT) begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (ld_gnt) begin
         mem_en_o    = 1'b1;
         mem_we_o    = ld_we_i;
         mem_addr_o  = ld_addr_i;
         mem_wdata_o = ld_wdata_i;
      end else if (fetch_gnt) begin
         mem_en_o   = 1'b1;
         mem_addr_o = fetch_addr_i;
      end
   end

   // Owner tag: rd_ld_q = 1 means the outstanding read belongs to the loader
   assign rd_valid_d = fetch_gnt | (ld_gnt & !ld_we_i);
   assign rd_ld_d    = ld_gnt;

   assign fetch_gnt_o    = fetch_gnt;
   assign ld_gnt_o       = ld_gnt;
   assign fetch_hold_o   = fetch_hold;
   assign fetch_rvalid_o = rd_valid_q & !rd_ld_q;
   assign ld_rvalid_o    = rd_valid_q & rd_ld_q;
   assign fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
   assign ld_rdata_o     = ld_rvalid_o ? mem_rdata_i : '0;
   assign arb_state_o    = (state_q == ST_RUN);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: one instance with MAX_WAIT=8, one with MAX_WAIT=0,
// each backed by its own synchronous-read RAM model.
module tb_imem_arbiter;

   localparam int unsigned AW = 7;

   logic          clk;
   logic          rst_n;
   logic          boot_done;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          ld_req;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_wdata;

   logic          fetch_gnt, fetch_rvalid, fetch_hold, ld_gnt, ld_rvalid, mem_en, mem_we, arb_state;
   logic [31:0]   fetch_rdata, ld_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   logic          z_fetch_gnt, z_fetch_rvalid, z_fetch_hold, z_ld_gnt, z_ld_rvalid, z_mem_en, z_mem_we, z_arb_state;
   logic [31:0]   z_fetch_rdata, z_ld_rdata, z_mem_wdata, z_mem_rdata;
   logic [AW-1:0] z_mem_addr;

   logic [31:0]   ram8 [0:(1<<AW)-1];
   logic [31:0]   ram0 [0:(1<<AW)-1];

   int errors;
   int checks;

   imem_arbiter #(.AW(AW), .MAX_WAIT(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .boot_done_i(boot_done),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
      .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
      .fetch_hold_o(fetch_hold),
      .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
      .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .arb_state_o(arb_state)
   );

   imem_arbiter #(.AW(AW), .MAX_WAIT(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .boot_done_i(boot_done),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
      .fetch_gnt_o(z_fetch_gnt), .fetch_rvalid_o(z_fetch_rvalid), .fetch_rdata_o(z_fetch_rdata),
      .fetch_hold_o(z_fetch_hold),
      .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
      .ld_gnt_o(z_ld_gnt), .ld_rvalid_o(z_ld_rvalid), .ld_rdata_o(z_ld_rdata),
      .mem_en_o(z_mem_en), .mem_we_o(z_mem_we), .mem_addr_o(z_mem_addr), .mem_wdata_o(z_mem_wdata),
      .mem_rdata_i(z_mem_rdata), .arb_state_o(z_arb_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram8[i] = '0;
         ram0[i] = '0;
      end
      mem_rdata   = '0;
      z_mem_rdata = '0;
   end

   always @(posedge clk) begin
      if (mem_en && mem_we) ram8[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram8[mem_addr];
      if (z_mem_en && z_mem_we) ram0[z_mem_addr] <= z_mem_wdata;
      if (z_mem_en && !z_mem_we) z_mem_rdata <= ram0[z_mem_addr];
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; boot_done = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
      #12;
      checks++; if (fetch_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b expected 1", fetch_hold); end
      checks++; if ({fetch_gnt, ld_gnt, fetch_rvalid, ld_rvalid} !== 4'b0000) begin errors++; $display("FAIL reset_gnt_rvalid: got %b expected 0000", {fetch_gnt, ld_gnt, fetch_rvalid, ld_rvalid}); end
      checks++; if (arb_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", arb_state); end
      checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_idle: got en=%b we=%b addr=%h wdata=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata); end
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_boot_load();
      for (int i = 0; i < 4; i++) begin
         ld_req = 1'b1; ld_we = 1'b1; ld_addr = AW'(i); ld_wdata = 32'hA000_0000 + 32'(i);
         fetch_req = 1'b1; fetch_addr = AW'(i);
         #1;
         checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL boot_ld_gnt[%0d]: got %b expected 1", i, ld_gnt); end
         checks++; if (fetch_gnt !== 1'b0 || fetch_hold !== 1'b1) begin errors++; $display("FAIL boot_fetch_blocked[%0d]: got gnt=%b hold=%b expected gnt=0 hold=1", i, fetch_gnt, fetch_hold); end
         checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL boot_mem_write[%0d]: got en=%b we=%b addr=%h wdata=%h expected 1 1 %h %h", i, mem_en, mem_we, mem_addr, mem_wdata, AW'(i), 32'hA000_0000 + 32'(i)); end
         next_cycle();
      end
      ld_req = 1'b0;
      #1;
      checks++; if (fetch_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL boot_fetch_only: got gnt=%b mem_en=%b expected 0 0", fetch_gnt, mem_en); end
      fetch_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_boot_done_fetch();
      boot_done = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_addr = AW'(6); ld_wdata = 32'h0000_0066;
      #1;
      checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL boot_done_same_cycle_ld_gnt: got %b expected 1", ld_gnt); end
      next_cycle();
      boot_done = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
      checks++; if (arb_state !== 1'b1 || fetch_hold !== 1'b0) begin errors++; $display("FAIL run_entry: got state=%b hold=%b expected 1 0", arb_state, fetch_hold); end
      fetch_req = 1'b1; fetch_addr = AW'(2);
      #1;
      checks++; if (fetch_gnt !== 1'b1 || mem_addr !== AW'(2) || mem_we !== 1'b0) begin errors++; $display("FAIL run_fetch_gnt: got gnt=%b addr=%h we=%b expected 1 02 0", fetch_gnt, mem_addr, mem_we); end
      next_cycle();
      fetch_req = 1'b0;
      checks++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hA000_0002) begin errors++; $display("FAIL run_fetch_rdata: got rvalid=%b rdata=%h expected 1 a0000002", fetch_rvalid, fetch_rdata); end
      checks++; if (ld_rvalid !== 1'b0 || ld_rdata !== 32'h0) begin errors++; $display("FAIL run_fetch_nonowner: got ld_rvalid=%b ld_rdata=%h expected 0 0", ld_rvalid, ld_rdata); end
      next_cycle();
      checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b expected 0", fetch_rvalid); end
      checks++; if (boot_done !== 1'b0 || mem_en !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL run_idle_mem: got en=%b addr=%h expected 0 0", mem_en, mem_addr); end
   endtask

   task automatic test_forced_slot();
      fetch_req = 1'b1; fetch_addr = '0;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = AW'(1);
      for (int c = 1; c <= 9; c++) begin
         #1;
         if (c < 9) begin
            checks++; if (ld_gnt !== 1'b0 || fetch_gnt !== 1'b1 || fetch_hold !== 1'b0) begin errors++; $display("FAIL starve_cycle[%0d]: got ld_gnt=%b fetch_gnt=%b hold=%b expected 0 1 0", c, ld_gnt, fetch_gnt, fetch_hold); end
         end else begin
            checks++; if (ld_gnt !== 1'b1 || fetch_gnt !== 1'b0 || fetch_hold !== 1'b1) begin errors++; $display("FAIL forced_slot: got ld_gnt=%b fetch_gnt=%b hold=%b expected 1 0 1", ld_gnt, fetch_gnt, fetch_hold); end
            checks++; if (mem_addr !== AW'(1) || mem_we !== 1'b0) begin errors++; $display("FAIL forced_mem: got addr=%h we=%b expected 01 0", mem_addr, mem_we); end
         end
         next_cycle();
      end
      checks++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hA000_0001) begin errors++; $display("FAIL forced_ld_rdata: got rvalid=%b rdata=%h expected 1 a0000001", ld_rvalid, ld_rdata); end
      checks++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h0) begin errors++; $display("FAIL forced_fetch_nonowner: got rvalid=%b rdata=%h expected 0 0", fetch_rvalid, fetch_rdata); end
      #1;
      checks++; if (ld_gnt !== 1'b0 || fetch_hold !== 1'b0) begin errors++; $display("FAIL wait_cnt_cleared: got ld_gnt=%b hold=%b expected 0 0", ld_gnt, fetch_hold); end
      ld_req = 1'b0; fetch_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_write_then_fetch();
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = AW'(5); ld_wdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(5) || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL run_ld_write: got gnt=%b we=%b addr=%h wdata=%h expected 1 1 05 deadbeef", ld_gnt, mem_we, mem_addr, mem_wdata); end
      next_cycle();
      checks++; if (ld_rvalid !== 1'b0 || fetch_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid: got ld_rvalid=%b fetch_rvalid=%b expected 0 0", ld_rvalid, fetch_rvalid); end
      ld_req = 1'b0; ld_we = 1'b0;
      fetch_req = 1'b1; fetch_addr = AW'(5);
      next_cycle();
      fetch_req = 1'b0;
      checks++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_then_fetch: got rvalid=%b rdata=%h expected 1 deadbeef", fetch_rvalid, fetch_rdata); end
      next_cycle();
   endtask

   task automatic test_reset_drops_read();
      fetch_req = 1'b1; fetch_addr = AW'(3);
      #1;
      checks++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL pre_reset_gnt: got %b expected 1", fetch_gnt); end
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      next_cycle();
      checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL reset_drops_read: got rvalid=%b expected 0", fetch_rvalid); end
      checks++; if (arb_state !== 1'b0 || fetch_hold !== 1'b1 || fetch_gnt !== 1'b0) begin errors++; $display("FAIL reset_back_to_boot: got state=%b hold=%b gnt=%b expected 0 1 0", arb_state, fetch_hold, fetch_gnt); end
      fetch_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_no_force();
      boot_done = 1'b1;
      next_cycle();
      boot_done = 1'b0;
      checks++; if (z_arb_state !== 1'b1) begin errors++; $display("FAIL nf_run_entry: got %b expected 1", z_arb_state); end
      fetch_req = 1'b1; fetch_addr = AW'(0);
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = AW'(1);
      for (int c = 1; c <= 50; c++) begin
         #1;
         checks++; if (z_ld_gnt !== 1'b0 || z_fetch_hold !== 1'b0 || z_fetch_gnt !== 1'b1) begin errors++; $display("FAIL no_force[%0d]: got ld_gnt=%b hold=%b fetch_gnt=%b expected 0 0 1", c, z_ld_gnt, z_fetch_hold, z_fetch_gnt); end
         next_cycle();
      end
      fetch_req = 1'b0;
      #1;
      checks++; if (z_ld_gnt !== 1'b1) begin errors++; $display("FAIL no_force_idle_slot: got %b expected 1", z_ld_gnt); end
      ld_req = 1'b0;
      next_cycle();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_boot_load();
      test_boot_done_fetch();
      test_forced_slot();
      test_write_then_fetch();
      test_reset_drops_read();
      test_no_force();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
